// File: rtl/seg_pkg.sv
// seg_pkg: shared segment-bus constants and types for the display path.
package seg_pkg;
    typedef logic [7:0] seg_byte_t;
    localparam seg_byte_t SEG_BLANK = 8'hFF;
    localparam int SEG_DP_BIT = 0;
    // Segment a..g live on bits 7..1; dp sits on bit 0.
    typedef enum logic [2:0] {
        SEG_G = 3'd1, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A
    } seg_bit_e;
endpackage

// File: rtl/scan_slot_counter.sv
// scan_slot_counter: slot/digit counters for the scan driver; exposes the
// next-cycle digit and phase so the top can register outputs aligned to state.
module scan_slot_counter #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    localparam int CW = $clog2(SCAN_DIV),
    localparam int DW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    output logic [DW-1:0] o_dig_nxt,
    output logic          o_show_nxt,
    output logic          o_capture,
    output logic          o_frame_start_nxt
);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [DW-1:0] r_dig;
    logic          w_wrap;
    always_comb begin
        w_wrap            = r_cnt == CW'(SCAN_DIV - 1);
        w_cnt_nxt         = w_wrap ? '0 : r_cnt + 1'b1;
        o_dig_nxt         = !w_wrap ? r_dig : (r_dig == DW'(NUM_DIGITS - 1)) ? '0 : r_dig + 1'b1;
        o_show_nxt        = w_cnt_nxt >= CW'(BLANK_CYCLES);
        o_capture         = (r_dig == '0) && (r_cnt == CW'(BLANK_CYCLES - 1));
        o_frame_start_nxt = o_capture;
    end
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_dig <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dig <= o_dig_nxt;
        end
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode 7-segment scanner with
// per-slot blanking and a frame-coherent shadow of the digit inputs.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    localparam int DW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    I_rst_n,
    input  logic [8*NUM_DIGITS-1:0] I_segs,
    input  logic [NUM_DIGITS-1:0]   I_digit_en,
    output logic [NUM_DIGITS-1:0]   O_an,
    output logic [7:0]              O_seg,
    output logic                    O_frame_start
);
    seg_byte_t             r_shadow [NUM_DIGITS];
    seg_byte_t             w_shadow_nxt [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_en;
    logic [NUM_DIGITS-1:0] w_en_nxt;
    logic [DW-1:0]         w_dig_nxt;
    logic                  w_show_nxt;
    logic                  w_capture;
    logic                  w_frame_start_nxt;
    logic                  w_lit;

    scan_slot_counter #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_cnt (
        .clk              (clk),
        .i_rst_n          (I_rst_n),
        .o_dig_nxt        (w_dig_nxt),
        .o_show_nxt       (w_show_nxt),
        .o_capture        (w_capture),
        .o_frame_start_nxt(w_frame_start_nxt)
    );

    // Outputs use the post-capture shadow so freshly captured data shows at once.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            w_shadow_nxt[i] = w_capture ? I_segs[8*i +: 8] : r_shadow[i];
        w_en_nxt = w_capture ? I_digit_en : r_en;
        w_lit    = w_show_nxt && w_en_nxt[w_dig_nxt];
    end

    always_ff @(posedge clk) begin
        if (!I_rst_n) begin
            r_shadow      <= '{default: SEG_BLANK};
            r_en          <= '0;
            O_an          <= '1;
            O_seg         <= SEG_BLANK;
            O_frame_start <= 1'b0;
        end else begin
            r_shadow      <= w_shadow_nxt;
            r_en          <= w_en_nxt;
            O_an          <= w_lit ? ~(NUM_DIGITS'(1) << w_dig_nxt) : '1;
            O_seg         <= w_lit ? w_shadow_nxt[w_dig_nxt] : SEG_BLANK;
            O_frame_start <= w_frame_start_nxt;
        end
    end
endmodule
